// File: rtl/fifo_deser_pkg.sv
// Shared constants for the serial link word FIFOs (transmit and receive sides).
// Default geometry plus the on-wire bit ordering.
package fifo_deser_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_ADDR_W    = 5;
    localparam int unsigned DEF_BIT_CNT_W = 3;

    // Bit 0 of each word travels first on the wire.
    localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/fifo_deser_bit_deserializer.sv
// Assembles serial bits into DATA_W-bit words; flags words cut short by a gap in valid.
module bit_deserializer
    import fifo_deser_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BIT_CNT_W = DEF_BIT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_in,
    input  logic              ser_in_valid,
    output logic [DATA_W-1:0] word,
    output logic              word_valid,
    output logic              frame_err
);

    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BIT_CNT_W-1:0] bit_idx;
    logic                 frame_err_q, frame_err_d;

    assign bit_idx = LSB_FIRST ? bit_cnt_q : BIT_CNT_W'(DATA_W - 1) - bit_cnt_q;

    // The completing bit is merged combinationally so the word is written on its own edge.
    always_comb begin
        word          = shift_q;
        word[bit_idx] = ser_in;
    end

    assign word_valid = ser_in_valid && (bit_cnt_q == BIT_CNT_W'(DATA_W - 1));

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        frame_err_d = 1'b0;
        if (ser_in_valid) begin
            shift_d   = word_valid ? '0 : word;
            bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (bit_cnt_q != '0) begin
            shift_d     = '0;
            bit_cnt_d   = '0;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

endmodule

// File: rtl/fifo_deser.sv
// Serial-in, word-out receive FIFO: deserializer feeding a circular buffer with a registered
// read port and level/empty/full/overflow status.
module fifo_deser
    import fifo_deser_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned BIT_CNT_W = DEF_BIT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_in,
    input  logic              ser_in_valid,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              frame_err
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] word;
    logic              word_valid;

    bit_deserializer #(
        .DATA_W   (DATA_W),
        .BIT_CNT_W(BIT_CNT_W)
    ) u_deser (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_in      (ser_in),
        .ser_in_valid(ser_in_valid),
        .word        (word),
        .word_valid  (word_valid),
        .frame_err   (frame_err)
    );

    logic [DATA_W-1:0] mem [Depth];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q, level_d;
    logic              empty_q, full_q, overflow_q;
    logic [DATA_W-1:0] data_out_q;
    logic              data_out_valid_q;
    logic              do_pop, do_write;

    // A pop frees a slot in the same cycle, so a full buffer can still accept a write.
    assign do_pop   = rd_en && !empty_q;
    assign do_write = word_valid && (!full_q || do_pop);

    always_comb begin
        level_d = level_q;
        if (do_write && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_write) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            empty_q          <= 1'b1;
            full_q           <= 1'b0;
            overflow_q       <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                data_out_q <= mem[rd_ptr_q];
            end
            level_q          <= level_d;
            empty_q          <= (level_d == '0);
            full_q           <= (level_d == (ADDR_W + 1)'(Depth));
            overflow_q       <= word_valid && full_q && !do_pop;
            data_out_valid_q <= do_pop;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign empty          = empty_q;
    assign full           = full_q;
    assign level          = level_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_fifo_deser.sv
// Directed self-checking bench for fifo_deser: framing, fill/overflow, concurrent push/pop,
// and asynchronous reset mid-word.
module tb_fifo_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_in;
    logic       ser_in_valid;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       empty;
    logic       full;
    logic [5:0] level;
    logic       overflow;
    logic       frame_err;

    int vectors = 0;
    int miscompares = 0;

    fifo_deser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ser_in        (ser_in),
        .ser_in_valid  (ser_in_valid),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .empty         (empty),
        .full          (full),
        .level         (level),
        .overflow      (overflow),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves ser_in_valid high so words can be chained; caller idles afterwards.
    task automatic send_word(input logic [7:0] w, input logic pop_last);
        for (int i = 0; i < 8; i++) begin
            ser_in       = w[i];
            ser_in_valid = 1'b1;
            rd_en        = pop_last && (i == 7);
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic idle();
        ser_in_valid = 1'b0;
        ser_in       = 1'b0;
        rd_en        = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) tick();
        vectors++;
        if ({data_out, data_out_valid, empty, full, level, overflow, frame_err} !==
            {8'h00, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got dout=%h dv=%b e=%b f=%b lvl=%0d ov=%b fe=%b want 00 0 1 0 0 0 0",
                     data_out, data_out_valid, empty, full, level, overflow, frame_err);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (empty !== 1'b1 || level !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_release: got e=%b lvl=%0d want e=1 lvl=0", empty, level);
        end
    endtask

    task automatic test_single_word();
        send_word(8'hA5, 1'b0);
        idle();
        vectors++;
        if (level !== 6'd1 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL single_level: got lvl=%0d e=%b want lvl=1 e=0", level, empty);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (data_out_valid !== 1'b1 || data_out !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_pop: got dv=%b dout=%h want dv=1 dout=a5", data_out_valid, data_out);
        end
        vectors++;
        if (level !== 6'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL single_drain: got lvl=%0d e=%b want lvl=0 e=1", level, empty);
        end
        tick();
        vectors++;
        if (data_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_dv_pulse: got dv=%b want 0", data_out_valid);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 32; i++) begin
            send_word(8'(i), 1'b0);
        end
        vectors++;
        if (full !== 1'b1 || level !== 6'd32 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got f=%b lvl=%0d ov=%b want f=1 lvl=32 ov=0", full, level, overflow);
        end
        send_word(8'h20, 1'b0);
        idle();
        vectors++;
        if (overflow !== 1'b1 || level !== 6'd32) begin
            miscompares++;
            $display("FAIL fill_overflow: got ov=%b lvl=%0d want ov=1 lvl=32", overflow, level);
        end
        tick();
        vectors++;
        if (overflow !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_ov_pulse: got ov=%b fe=%b want ov=0 fe=0", overflow, frame_err);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            vectors++;
            if (data_out_valid !== 1'b1 || data_out !== 8'(i)) begin
                miscompares++;
                $display("FAIL fill_pop%0d: got dv=%b dout=%h want dv=1 dout=%h",
                         i, data_out_valid, data_out, 8'(i));
            end
        end
        rd_en = 1'b0;
        vectors++;
        if (empty !== 1'b1 || level !== 6'd0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_empty: got e=%b lvl=%0d f=%b want e=1 lvl=0 f=0", empty, level, full);
        end
        tick();
    endtask

    task automatic test_frame_err();
        for (int i = 0; i < 5; i++) begin
            ser_in       = 1'b1;
            ser_in_valid = 1'b1;
            tick();
        end
        idle();
        tick();
        vectors++;
        if (frame_err !== 1'b1 || level !== 6'd0) begin
            miscompares++;
            $display("FAIL frame_err_pulse: got fe=%b lvl=%0d want fe=1 lvl=0", frame_err, level);
        end
        tick();
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_err_single: got fe=%b want 0", frame_err);
        end
        send_word(8'h3C, 1'b0);
        idle();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (data_out_valid !== 1'b1 || data_out !== 8'h3C || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_recover: got dv=%b dout=%h e=%b want dv=1 dout=3c e=1",
                     data_out_valid, data_out, empty);
        end
        tick();
    endtask

    task automatic test_full_pop_write();
        for (int i = 0; i < 32; i++) begin
            send_word(8'h40 + 8'(i), 1'b0);
        end
        send_word(8'h77, 1'b1);
        idle();
        vectors++;
        if (overflow !== 1'b0 || level !== 6'd32 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL fullpop_status: got ov=%b lvl=%0d f=%b want ov=0 lvl=32 f=1",
                     overflow, level, full);
        end
        vectors++;
        if (data_out_valid !== 1'b1 || data_out !== 8'h40) begin
            miscompares++;
            $display("FAIL fullpop_first: got dv=%b dout=%h want dv=1 dout=40", data_out_valid, data_out);
        end
        rd_en = 1'b1;
        for (int i = 1; i < 33; i++) begin
            tick();
            vectors++;
            if (data_out !== ((i == 32) ? 8'h77 : 8'h40 + 8'(i))) begin
                miscompares++;
                $display("FAIL fullpop_drain%0d: got dout=%h want %h",
                         i, data_out, (i == 32) ? 8'h77 : 8'h40 + 8'(i));
            end
        end
        rd_en = 1'b0;
        tick();
        vectors++;
        if (empty !== 1'b1 || data_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_empty: got e=%b dv=%b want e=1 dv=0", empty, data_out_valid);
        end
    endtask

    task automatic test_empty_pop_write();
        send_word(8'h5A, 1'b1);
        idle();
        vectors++;
        if (data_out_valid !== 1'b0 || data_out !== 8'h77 || level !== 6'd1) begin
            miscompares++;
            $display("FAIL emptypop_bypass: got dv=%b dout=%h lvl=%0d want dv=0 dout=77 lvl=1",
                     data_out_valid, data_out, level);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (data_out_valid !== 1'b1 || data_out !== 8'h5A) begin
            miscompares++;
            $display("FAIL emptypop_read: got dv=%b dout=%h want dv=1 dout=5a", data_out_valid, data_out);
        end
        tick();
    endtask

    task automatic test_reset_mid_word();
        send_word(8'h11, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ser_in       = 1'b1;
            ser_in_valid = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        idle();
        #1;
        vectors++;
        if ({data_out, data_out_valid, empty, full, level, overflow, frame_err} !==
            {8'h00, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_outputs: got dout=%h dv=%b e=%b f=%b lvl=%0d ov=%b fe=%b want 00 0 1 0 0 0 0",
                     data_out, data_out_valid, empty, full, level, overflow, frame_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_fe: got fe=%b want 0", frame_err);
        end
        send_word(8'h96, 1'b0);
        idle();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        vectors++;
        if (data_out_valid !== 1'b1 || data_out !== 8'h96 || level !== 6'd0) begin
            miscompares++;
            $display("FAIL midreset_word: got dv=%b dout=%h lvl=%0d want dv=1 dout=96 lvl=0",
                     data_out_valid, data_out, level);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_overflow();
        test_frame_err();
        test_full_pop_write();
        test_empty_pop_write();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
